vram_dma_ctrl: RTL and testbench

//  Word-granular VRAM fill/copy DMA engine that shares the 8-bit host port (if0) of vram_if with the CPU bus.

---
 rtl/vram_dma_ctrl.sv | 161 ++++++++++++++++
 tb/tb_vram_dma_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_dma_ctrl.sv
// VRAM fill/copy DMA engine sharing the vram_if host port (if0) with the CPU; the host always wins.
// Optional VRAM_DMA_STRIDE_EN adds dma_stride[7:0], a per-word destination step latched at start.
module vram_dma_ctrl #(
  parameter int AW    = 15,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [16:0]      host_addr,
  input  logic [1:0]       host_wrpattern,
  input  logic [7:0]       host_wrdata,
  input  logic [31:0]      host_cache32,
  input  logic             host_strobe,
  input  logic             host_write,
  input  logic             dma_start,
  input  logic             dma_abort,
  input  logic             dma_mode,
  input  logic [AW-1:0]    dma_src,
  input  logic [AW-1:0]    dma_dst,
  input  logic [LEN_W-1:0] dma_len,
  input  logic [31:0]      dma_fill,
`ifdef VRAM_DMA_STRIDE_EN
  input  logic [7:0]       dma_stride,
`endif
  output logic             dma_busy,
  output logic             dma_done,
  output logic [16:0]      if0_addr,
  output logic [1:0]       if0_wrpattern,
  output logic [7:0]       if0_wrdata,
  output logic [31:0]      if0_cache32,
  output logic             if0_strobe,
  output logic             if0_write,
  input  logic [31:0]      if0_rddata32
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_WR,
    S_ZERO,
    S_DONE
  } state_t;

  state_t           state;
  logic             mode_r;
  logic [AW-1:0]    src_r;
  logic [AW-1:0]    dst_r;
  logic [LEN_W-1:0] rem_r;
  logic [31:0]      data_r;
  logic [AW-1:0]    dst_step;
  logic             grant;
  logic             dma_req;

`ifdef VRAM_DMA_STRIDE_EN
  logic [7:0]       stride_r;
  assign dst_step = AW'(stride_r);
`else
  assign dst_step = AW'(1);
`endif

  assign grant   = ~host_strobe;
  assign dma_req = (state == S_RD) || (state == S_WR);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      dma_busy <= 1'b0;
      dma_done <= 1'b0;
      mode_r   <= 1'b0;
      src_r    <= '0;
      dst_r    <= '0;
      rem_r    <= '0;
      data_r   <= '0;
`ifdef VRAM_DMA_STRIDE_EN
      stride_r <= '0;
`endif
    end else begin
      dma_done <= 1'b0;
      if (dma_abort && state != S_IDLE) begin
        state    <= S_IDLE;
        dma_busy <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (dma_start && !dma_abort) begin
              mode_r   <= dma_mode;
              src_r    <= dma_src;
              dst_r    <= dma_dst;
              rem_r    <= dma_len;
              // Fill mode writes data_r directly; copy mode overwrites it in CAP.
              data_r   <= dma_fill;
`ifdef VRAM_DMA_STRIDE_EN
              stride_r <= dma_stride;
`endif
              dma_busy <= 1'b1;
              if (dma_len == '0)
                state <= S_ZERO;
              else if (dma_mode)
                state <= S_RD;
              else
                state <= S_WR;
            end
          end
          S_RD: begin
            if (grant)
              state <= S_CAP;
          end
          S_CAP: begin
            data_r <= if0_rddata32;
            state  <= S_WR;
          end
          S_WR: begin
            if (grant) begin
              dst_r <= dst_r + dst_step;
              src_r <= src_r + AW'(1);
              rem_r <= rem_r - LEN_W'(1);
              if (rem_r == LEN_W'(1)) begin
                state    <= S_DONE;
                dma_done <= 1'b1;
              end else if (mode_r) begin
                state <= S_RD;
              end
            end
          end
          // Zero-length transfers spend one idle busy cycle so done lands two cycles after start.
          S_ZERO: begin
            state    <= S_DONE;
            dma_done <= 1'b1;
          end
          S_DONE: begin
            state    <= S_IDLE;
            dma_busy <= 1'b0;
          end
          default: begin
            state    <= S_IDLE;
            dma_busy <= 1'b0;
          end
        endcase
      end
    end
  end

  always_comb begin
    if0_addr      = host_addr;
    if0_wrpattern = host_wrpattern;
    if0_wrdata    = host_wrdata;
    if0_cache32   = host_cache32;
    if0_strobe    = host_strobe;
    if0_write     = host_write;
    if (!host_strobe && dma_req) begin
      if0_addr      = 17'({(state == S_RD) ? src_r : dst_r, 2'b00});
      if0_wrpattern = (state == S_WR) ? 2'b11 : 2'b00;
      if0_wrdata    = 8'h00;
      if0_cache32   = data_r;
      if0_strobe    = 1'b1;
      if0_write     = (state == S_WR);
    end
  end

endmodule

// File: tb/tb_vram_dma_ctrl.sv
// Self-checking bench for vram_dma_ctrl: VRAM behavioural model on if0, scheduled host traffic,
// and expected results computed from the transfer rules.
module tb_vram_dma_ctrl;
  localparam int AW    = 15;
  localparam int LEN_W = 16;
  localparam int unsigned MASK = 32'h7FFF;

  logic             clk;
  logic             reset_n;
  logic [16:0]      host_addr;
  logic [1:0]       host_wrpattern;
  logic [7:0]       host_wrdata;
  logic [31:0]      host_cache32;
  logic             host_strobe;
  logic             host_write;
  logic             dma_start;
  logic             dma_abort;
  logic             dma_mode;
  logic [AW-1:0]    dma_src;
  logic [AW-1:0]    dma_dst;
  logic [LEN_W-1:0] dma_len;
  logic [31:0]      dma_fill;
  logic             dma_busy;
  logic             dma_done;
  logic [16:0]      if0_addr;
  logic [1:0]       if0_wrpattern;
  logic [7:0]       if0_wrdata;
  logic [31:0]      if0_cache32;
  logic             if0_strobe;
  logic             if0_write;
  logic [31:0]      if0_rddata32;

  vram_dma_ctrl #(.AW(AW), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .host_addr(host_addr), .host_wrpattern(host_wrpattern), .host_wrdata(host_wrdata),
    .host_cache32(host_cache32), .host_strobe(host_strobe), .host_write(host_write),
    .dma_start(dma_start), .dma_abort(dma_abort), .dma_mode(dma_mode),
    .dma_src(dma_src), .dma_dst(dma_dst), .dma_len(dma_len), .dma_fill(dma_fill),
    .dma_busy(dma_busy), .dma_done(dma_done),
    .if0_addr(if0_addr), .if0_wrpattern(if0_wrpattern), .if0_wrdata(if0_wrdata),
    .if0_cache32(if0_cache32), .if0_strobe(if0_strobe), .if0_write(if0_write),
    .if0_rddata32(if0_rddata32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned addr;
    int          cyc;
  } wr_t;

  logic [31:0] mem     [0:32767];
  logic [31:0] exp_mem [0:32767];
  wr_t         wr_q[$];
  wr_t         wr_tmp;
  bit          hpat   [0:255];
  logic        busy_h [0:255];
  int cyc = 0, start_cyc = 0;
  int fmt_bad = 0, dma_strobes = 0, done_cnt = 0, pt_bad = 0;
  int checks = 0, fails = 0;

  // VRAM model: writes land at the edge, read data appears the following cycle.
  always @(posedge clk) begin
    if (if0_strobe) begin
      if (!host_strobe) dma_strobes++;
      if (if0_write) begin
        if (!host_strobe) begin
          wr_tmp.addr = 32'(if0_addr[16:2]);
          wr_tmp.cyc  = cyc - start_cyc;
          wr_q.push_back(wr_tmp);
          if (if0_wrpattern !== 2'b11 || if0_addr[1:0] !== 2'b00 || if0_wrdata !== 8'h00)
            fmt_bad++;
        end
        mem[if0_addr[16:2]] = if0_cache32;
      end else begin
        if0_rddata32 <= mem[if0_addr[16:2]];
      end
    end else begin
      if0_rddata32 <= $urandom;
    end
    cyc++;
  end

  function automatic int model_done(input bit mode, input int unsigned len);
    int t = 1;
    if (len == 0) return 2;
    for (int unsigned w = 0; w < len; w++) begin
      if (mode) begin
        while (t < 255 && hpat[t]) t++;
        t += 2;
      end
      while (t < 255 && hpat[t]) t++;
      t++;
    end
    return t;
  endfunction

  task automatic model_xfer(input bit mode, input int unsigned src, input int unsigned dst,
                            input int unsigned len, input logic [31:0] fill);
    for (int unsigned i = 0; i < len; i++)
      exp_mem[(dst + i) & MASK] = mode ? exp_mem[(src + i) & MASK] : fill;
  endtask

  function automatic int mem_diffs();
    int n = 0;
    for (int i = 0; i < 32768; i++)
      if (mem[i] !== exp_mem[i]) n++;
    return n;
  endfunction

  task automatic clear_hpat();
    for (int i = 0; i < 256; i++) hpat[i] = 1'b0;
  endtask

  // Issues a start and drives the host pattern per relative cycle; done_rel=-1 if no done seen.
  task automatic run_dma(input bit mode, input int unsigned src, input int unsigned dst,
                         input int unsigned len, input logic [31:0] fill,
                         input int abort_rel, input int restart_rel, input int max_rel,
                         output int done_rel);
    @(negedge clk);
    wr_q.delete();
    fmt_bad = 0; dma_strobes = 0; done_cnt = 0; pt_bad = 0;
    start_cyc = cyc;
    dma_mode = mode; dma_src = AW'(src); dma_dst = AW'(dst);
    dma_len = LEN_W'(len); dma_fill = fill;
    dma_start = 1'b1; dma_abort = 1'b0;
    host_strobe = 1'b0; host_write = 1'b0;
    done_rel = -1;
    for (int r = 1; r <= max_rel && r < 256; r++) begin
      @(negedge clk);
      dma_start = 1'b0; dma_abort = 1'b0;
      busy_h[r] = dma_busy;
      if (dma_done === 1'b1) begin
        done_cnt++;
        if (done_rel < 0) done_rel = r;
      end
      if (r == abort_rel) dma_abort = 1'b1;
      if (r == restart_rel) begin
        dma_start = 1'b1;
        dma_mode = $urandom; dma_src = AW'($urandom); dma_dst = AW'($urandom);
        dma_len = LEN_W'($urandom_range(0, 5)); dma_fill = $urandom;
      end
      host_strobe = hpat[r]; host_write = 1'b0;
      host_addr = 17'($urandom); host_wrpattern = 2'($urandom);
      host_wrdata = 8'($urandom); host_cache32 = $urandom;
      #1;
      if (host_strobe && (if0_strobe !== 1'b1 || if0_write !== host_write || if0_addr !== host_addr ||
          if0_wrpattern !== host_wrpattern || if0_wrdata !== host_wrdata || if0_cache32 !== host_cache32))
        pt_bad++;
      if (done_rel >= 0 && r >= done_rel + 2) break;
    end
    host_strobe = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      host_strobe = $urandom; host_addr = 17'($urandom); host_write = $urandom;
      #1;
      checks++; if (dma_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", dma_busy); end
      checks++; if (dma_done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", dma_done); end
      checks++; if (if0_strobe !== host_strobe || if0_addr !== host_addr || if0_write !== host_write) begin
        fails++; $display("FAIL reset_passthru: strobe %b addr %h, expected %b %h", if0_strobe, if0_addr, host_strobe, host_addr);
      end
    end
    @(negedge clk);
    reset_n = 1'b1; host_strobe = 1'b0; host_write = 1'b0;
  endtask

  task automatic test_fill_basic();
    int dr;
    clear_hpat();
    exp_mem = mem;
    model_xfer(1'b0, 0, 32'h10, 4, 32'hDEADBEEF);
    run_dma(1'b0, 0, 32'h10, 4, 32'hDEADBEEF, -1, -1, 40, dr);
    checks++; if (dr !== 5) begin fails++; $display("FAIL fill_done_cycle: got %0d expected 5", dr); end
    checks++; if (wr_q.size() !== 4) begin fails++; $display("FAIL fill_write_count: got %0d expected 4", wr_q.size()); end
    for (int i = 0; i < 4 && i < wr_q.size(); i++) begin
      checks++;
      if (wr_q[i].addr !== 32'h10 + i || wr_q[i].cyc !== i + 1) begin
        fails++; $display("FAIL fill_write%0d: got addr %h cycle %0d expected %h %0d", i, wr_q[i].addr, wr_q[i].cyc, 32'h10 + i, i + 1);
      end
    end
    checks++; if (busy_h[1] !== 1'b1 || busy_h[6] !== 1'b0) begin
      fails++; $display("FAIL fill_busy: got %b/%b expected 1/0", busy_h[1], busy_h[6]);
    end
    checks++; if (fmt_bad !== 0) begin fails++; $display("FAIL fill_blit_format: got %0d bad expected 0", fmt_bad); end
    checks++; if (mem_diffs() !== 0) begin fails++; $display("FAIL fill_mem: got %0d wrong words expected 0", mem_diffs()); end
  endtask

  task automatic test_copy_basic();
    int dr;
    clear_hpat();
    mem[32'h100] = 32'h11223344; mem[32'h101] = 32'h55667788;
    exp_mem = mem;
    model_xfer(1'b1, 32'h100, 32'h200, 2, 32'h0);
    run_dma(1'b1, 32'h100, 32'h200, 2, 32'hCAFEF00D, -1, -1, 40, dr);
    checks++; if (dr !== 7) begin fails++; $display("FAIL copy_done_cycle: got %0d expected 7", dr); end
    checks++; if (wr_q.size() !== 2 || (wr_q.size() == 2 && (wr_q[0].cyc !== 3 || wr_q[1].cyc !== 6))) begin
      fails++; $display("FAIL copy_write_timing: got %0d writes expected 2 at cycles 3,6", wr_q.size());
    end
    checks++; if (mem[32'h200] !== 32'h11223344 || mem[32'h201] !== 32'h55667788) begin
      fails++; $display("FAIL copy_data: got %h %h expected 11223344 55667788", mem[32'h200], mem[32'h201]);
    end
    checks++; if (mem_diffs() !== 0) begin fails++; $display("FAIL copy_mem: got %0d wrong words expected 0", mem_diffs()); end
  endtask

  task automatic test_host_contention();
    int dr;
    int unsigned dst;
    clear_hpat();
    hpat[2] = 1'b1; hpat[3] = 1'b1;
    dst = $urandom_range(32'h1000, 32'h6000);
    exp_mem = mem;
    model_xfer(1'b0, 0, dst, 3, 32'hA5A5_0F0F);
    run_dma(1'b0, 0, dst, 3, 32'hA5A5_0F0F, -1, -1, 40, dr);
    checks++; if (dr !== model_done(1'b0, 3)) begin fails++; $display("FAIL contention_done: got %0d expected %0d", dr, model_done(1'b0, 3)); end
    checks++; if (pt_bad !== 0) begin fails++; $display("FAIL contention_passthru: got %0d bad cycles expected 0", pt_bad); end
    checks++; if (wr_q.size() !== 3) begin fails++; $display("FAIL contention_writes: got %0d expected 3", wr_q.size()); end
    checks++; if (mem_diffs() !== 0) begin fails++; $display("FAIL contention_mem: got %0d wrong words expected 0", mem_diffs()); end
  endtask

  task automatic test_cap_host();
    int dr;
    clear_hpat();
    hpat[2] = 1'b1;
    mem[32'h300] = 32'h0BAD_F00D;
    exp_mem = mem;
    model_xfer(1'b1, 32'h300, 32'h400, 1, 32'h0);
    run_dma(1'b1, 32'h300, 32'h400, 1, 32'h0, -1, -1, 40, dr);
    checks++; if (dr !== 4) begin fails++; $display("FAIL cap_done: got %0d expected 4", dr); end
    checks++; if (mem[32'h400] !== 32'h0BAD_F00D) begin fails++; $display("FAIL cap_data: got %h expected 0badf00d", mem[32'h400]); end
    checks++; if (mem_diffs() !== 0) begin fails++; $display("FAIL cap_mem: got %0d wrong words expected 0", mem_diffs()); end
  endtask

  task automatic test_wrap();
    int dr;
    clear_hpat();
    exp_mem = mem;
    model_xfer(1'b0, 0, 32'h7FFF, 3, 32'h1357_9BDF);
    run_dma(1'b0, 0, 32'h7FFF, 3, 32'h1357_9BDF, -1, -1, 40, dr);
    checks++; if (wr_q.size() !== 3 || (wr_q.size() == 3 && (wr_q[0].addr !== 32'h7FFF || wr_q[1].addr !== 0 || wr_q[2].addr !== 1))) begin
      fails++; $display("FAIL wrap_addrs: got %0d writes expected 7fff,0000,0001", wr_q.size());
    end
    checks++; if (mem_diffs() !== 0) begin fails++; $display("FAIL wrap_mem: got %0d wrong words expected 0", mem_diffs()); end
  endtask

  task automatic test_zero_len_abort();
    int dr;
    int unsigned dst;
    clear_hpat();
    exp_mem = mem;
    run_dma(1'b0, 0, 32'h50, 0, 32'hFFFF_FFFF, -1, -1, 20, dr);
    checks++; if (dr !== 2) begin fails++; $display("FAIL zero_len_done: got %0d expected 2", dr); end
    checks++; if (dma_strobes !== 0) begin fails++; $display("FAIL zero_len_strobes: got %0d expected 0", dma_strobes); end

    dst = $urandom_range(32'h2000, 32'h3000);
    exp_mem = mem;
    model_xfer(1'b0, 0, dst, 2, 32'h5555_AAAA);
    run_dma(1'b0, 0, dst, 8, 32'h5555_AAAA, 2, -1, 12, dr);
    checks++; if (done_cnt !== 0) begin fails++; $display("FAIL abort_no_done: got %0d pulses expected 0", done_cnt); end
    checks++; if (wr_q.size() !== 2) begin fails++; $display("FAIL abort_writes: got %0d expected 2", wr_q.size()); end
    checks++; if (busy_h[3] !== 1'b0) begin fails++; $display("FAIL abort_busy: got %b expected 0", busy_h[3]); end
    checks++; if (mem_diffs() !== 0) begin fails++; $display("FAIL abort_mem: got %0d wrong words expected 0", mem_diffs()); end

    @(negedge clk);
    dma_strobes = 0;
    dma_mode = 1'b0; dma_len = 16'd4; dma_start = 1'b1; dma_abort = 1'b1;
    @(negedge clk);
    dma_start = 1'b0; dma_abort = 1'b0;
    checks++; if (dma_busy !== 1'b0) begin fails++; $display("FAIL abort_start_busy: got %b expected 0", dma_busy); end
    repeat (3) @(negedge clk);
    checks++; if (dma_strobes !== 0) begin fails++; $display("FAIL abort_start_strobes: got %0d expected 0", dma_strobes); end
  endtask

  task automatic test_random();
    int dr, exp_dr;
    bit mode;
    int unsigned src, dst, len;
    logic [31:0] fill;
    for (int it = 0; it < 8; it++) begin
      clear_hpat();
      for (int r = 1; r < 60; r++) hpat[r] = ($urandom_range(0, 3) == 0);
      mode = $urandom; src = $urandom & MASK; dst = $urandom & MASK;
      len = $urandom_range(2, 10); fill = $urandom;
      exp_mem = mem;
      model_xfer(mode, src, dst, len, fill);
      exp_dr = model_done(mode, len);
      run_dma(mode, src, dst, len, fill, -1, 1 + $urandom_range(0, 1), 220, dr);
      checks++; if (dr !== exp_dr) begin fails++; $display("FAIL rand%0d_done: got %0d expected %0d", it, dr, exp_dr); end
      checks++; if (wr_q.size() !== len || done_cnt !== 1) begin
        fails++; $display("FAIL rand%0d_counts: got %0d writes %0d dones expected %0d 1", it, wr_q.size(), done_cnt, len);
      end
      checks++; if (pt_bad !== 0 || fmt_bad !== 0) begin
        fails++; $display("FAIL rand%0d_bus: got %0d passthru %0d format errors expected 0", it, pt_bad, fmt_bad);
      end
      checks++; if (mem_diffs() !== 0) begin fails++; $display("FAIL rand%0d_mem: got %0d wrong words expected 0", it, mem_diffs()); end
    end
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = $urandom;
    clear_hpat();
    reset_n = 1'b0;
    host_addr = '0; host_wrpattern = '0; host_wrdata = '0; host_cache32 = '0;
    host_strobe = 1'b0; host_write = 1'b0;
    dma_start = 1'b0; dma_abort = 1'b0; dma_mode = 1'b0;
    dma_src = '0; dma_dst = '0; dma_len = '0; dma_fill = '0;
    test_reset();
    test_fill_basic();
    test_copy_basic();
    test_host_contention();
    test_cap_host();
    test_wrap();
    test_zero_len_abort();
    test_random();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
